spi_slave: RTL and testbench

- 12-bit SPI responder; the far end of our SPI master link.
- Frame: LOAD active-low (idles high); SCLK idles low; MSB first.
- Master drives MOSI after SCLK falling edges and samples MISO on SCLK rising edges.
- Block oversamples LOAD/SCLK/MOSI on clk (no SCLK clock domain): captures MOSI into DO, shifts DI out on MISO, pulses rx_valid at frame end.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_slave.sv | 173 +++++++++++++++++
 tb/tb_spi_slave.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: frame width, FSM states and
// the idle levels the input synchronizers are preset to.
package spi_pkg;

  localparam int SPI_M = 12;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } spi_state_e;

  localparam logic LOAD_IDLE = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic MOSI_IDLE = 1'b0;

  // SCLK rising-edge counter saturates so long frames never wrap to a small count.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer plus history flop for one SPI pin.
// Produces the synchronized level and single-clk rise/fall strobes.
// IDLE_LVL is the level the chain is preset to under clr so that reset
// never manufactures an edge on an idle line.
module spi_sync_edge #(
  parameter int   SYNC     = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC-1:0] sync_q;
  logic            hist_q;

  // Synchronizer chain and one-clk history of the synchronized level.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= {SYNC{IDLE_LVL}};
      hist_q <= IDLE_LVL;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], d_i};
      hist_q <= sync_q[SYNC-1];
    end
  end

  assign s_o    = sync_q[SYNC-1];
  assign rise_o =  sync_q[SYNC-1] & ~hist_q;
  assign fall_o = ~sync_q[SYNC-1] &  hist_q;

endmodule

// File: rtl/spi_slave.sv
// 12-bit SPI responder, oversampled on clk (no SCLK clock domain).
// MSB first; MOSI captured on SCLK rise, MISO advanced on SCLK fall.
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN adds the frame_err output,
// set on frame end when the SCLK rise count differs from M.
//
// state     | meaning
// ----------+----------------------------------------------------------
// WAIT_IDLE | after reset: flush synchronizers, wait for LOAD high
// IDLE      | between frames, waiting for LOAD to fall
// ACTIVE    | frame in progress: shift on SCLK edges until LOAD rises
module spi_slave
  import spi_pkg::*;
#(
  parameter int M    = SPI_M,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         LOAD,
  input  logic         SCLK,
  input  logic         MOSI,
  input  logic [M-1:0] DI,
  output logic         MISO,
  output logic [M-1:0] DO,
  output logic         rx_valid,
  output logic         busy,
  output logic [7:0]   bit_cnt
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic         frame_err
`endif
);

  // Clocks needed before the synchronized LOAD reflects the pin rather than
  // the reset preset; without this wait a reset taken mid-frame would see
  // the preset high, leave WAIT_IDLE, and then join the frame on a fake fall.
  localparam logic [2:0] FLUSH_INIT = 3'(SYNC + 1);

  logic ld_s, ld_rise, ld_fall;
  logic unused_sck_s, sck_rise, sck_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.SYNC(SYNC), .IDLE_LVL(LOAD_IDLE)) u_sync_load (
    .clk    (clk),
    .clr    (clr),
    .d_i    (LOAD),
    .s_o    (ld_s),
    .rise_o (ld_rise),
    .fall_o (ld_fall)
  );

  spi_sync_edge #(.SYNC(SYNC), .IDLE_LVL(SCLK_IDLE)) u_sync_sclk (
    .clk    (clk),
    .clr    (clr),
    .d_i    (SCLK),
    .s_o    (unused_sck_s),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.SYNC(SYNC), .IDLE_LVL(MOSI_IDLE)) u_sync_mosi (
    .clk    (clk),
    .clr    (clr),
    .d_i    (MOSI),
    .s_o    (mosi_s),
    .rise_o (unused_mosi_rise),
    .fall_o (unused_mosi_fall)
  );

  spi_state_e     state_q, state_d;
  logic [M-1:0]   tx_q, tx_d;
  logic [M-1:0]   rx_q, rx_d;
  logic [M-1:0]   do_q, do_d;
  logic           miso_q, miso_d;
  logic           rxv_q, rxv_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [2:0]     flush_q, flush_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic           ferr_q, ferr_d;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= WAIT_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      do_q    <= '0;
      miso_q  <= 1'b0;
      rxv_q   <= 1'b0;
      cnt_q   <= '0;
      flush_q <= FLUSH_INIT;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      do_q    <= do_d;
      miso_q  <= miso_d;
      rxv_q   <= rxv_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

  // Next-state and shift logic; LOAD release takes priority over SCLK edges.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    do_d    = do_q;
    miso_d  = miso_q;
    rxv_d   = 1'b0;
    cnt_d   = cnt_q;
    flush_d = flush_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ferr_d  = ferr_q;
`endif
    unique case (state_q)
      WAIT_IDLE: begin
        if (flush_q != 3'd0) begin
          flush_d = flush_q - 3'd1;
        end else if (ld_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (ld_fall) begin
          tx_d    = DI;
          miso_d  = DI[M-1];
          rx_d    = '0;
          cnt_d   = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ld_rise) begin
          do_d    = rx_q;
          rxv_d   = 1'b1;
          state_d = IDLE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
          ferr_d  = (cnt_q != 8'(M));
`endif
        end else begin
          if (sck_rise) begin
            rx_d  = {rx_q[M-2:0], mosi_s};
            cnt_d = sat_inc8(cnt_q);
          end
          if (sck_fall) begin
            tx_d   = tx_q << 1;
            miso_d = tx_q[M-2];
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign MISO     = miso_q;
  assign DO       = do_q;
  assign rx_valid = rxv_q;
  assign busy     = (state_q == ACTIVE);
  assign bit_cnt  = cnt_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a 50-clk half-period SPI master drives directed
// frames; expected DO words are queued at frame end and checked by a
// monitor whenever rx_valid pulses.
module tb_spi_slave;

  localparam int M    = 12;
  localparam int SYNC = 2;
  localparam int HALF = 50;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          LOAD = 1'b1;
  logic          SCLK = 1'b0;
  logic          MOSI = 1'b0;
  logic [M-1:0]  DI = '0;
  logic          MISO;
  logic [M-1:0]  DO;
  logic          rx_valid;
  logic          busy;
  logic [7:0]    bit_cnt;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic          frame_err;
`endif

  spi_slave #(.M(M), .SYNC(SYNC)) dut (
    .clk      (clk),
    .clr      (clr),
    .LOAD     (LOAD),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .DI       (DI),
    .MISO     (MISO),
    .DO       (DO),
    .rx_valid (rx_valid),
    .busy     (busy),
    .bit_cnt  (bit_cnt)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ld_cyc = 0;

  typedef struct {
    logic [M-1:0] d;
    logic         fe;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rx_valid pulse consumes one expected frame result.
  always @(negedge clk) begin
    if (!clr && rx_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_valid_unexpected: got pulse with DO=0x%0h expected none", DO);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("do_word", 32'(DO), 32'(e.d));
        check("rx_latency", 32'(cyc - ld_cyc), 32'(SYNC + 1));
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("frame_err", 32'(frame_err), 32'(e.fe));
`endif
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master frame. abort_at>0 pulses clr after that bit's SCLK fall;
  // di_at>0 changes DI to di_new after that bit.
  task automatic xfer(input logic [15:0] mw, input int nb, input logic [M-1:0] exp_do,
                      input int abort_at, input int di_at, input logic [M-1:0] di_new,
                      output logic [15:0] sw);
    logic [15:0] msr;
    sw  = '0;
    msr = mw << (16 - nb);
    @(negedge clk);
    LOAD = 1'b0;
    MOSI = (nb > 0) ? msr[15] : 1'b0;
    clks((nb == 0) ? 200 : HALF);
    for (int i = 0; i < nb; i++) begin
      sw   = {sw[14:0], MISO};
      SCLK = 1'b1;
      clks(HALF);
      SCLK = 1'b0;
      msr  = msr << 1;
      MOSI = msr[15];
      if (i + 1 == di_at) DI = di_new;
      if (i + 1 == abort_at) begin
        clr = 1'b1;
        #1;
        check("clr_miso", 32'(MISO), 32'h0);
        check("clr_do", 32'(DO), 32'h0);
        check("clr_busy", 32'(busy), 32'h0);
        clks(2);
        clr = 1'b0;
      end
      clks(HALF);
    end
    if (abort_at > 0) check("bit_cnt_ignored", 32'(bit_cnt), 32'h0);
    else              check("bit_cnt", 32'(bit_cnt), 32'((nb > 255) ? 255 : nb));
    if (abort_at == 0) sb.push_back('{d: exp_do, fe: (nb != M)});
    @(negedge clk);
    LOAD   = 1'b1;
    ld_cyc = cyc;
    clks(60);
  endtask

  logic [15:0] sw;

  initial begin
    #1;
    check("rst_miso", 32'(MISO), 32'h0);
    check("rst_do", 32'(DO), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'h0);
    clks(3);
    clr = 1'b0;
    clks(10);

    // Nominal frame
    DI = 12'hA5C;
    xfer(16'h3F1, 12, 12'h3F1, 0, 0, '0, sw);
    check("miso_nominal", 32'(sw), 32'hA5C);

    // Back-to-back with DI change between frames
    DI = 12'h123;
    xfer(16'h001, 12, 12'h001, 0, 0, '0, sw);
    check("miso_b2b_1", 32'(sw), 32'h123);
    DI = 12'h7FF;
    xfer(16'h800, 12, 12'h800, 0, 0, '0, sw);
    check("miso_b2b_2", 32'(sw), 32'h7FF);

    // Short frame: 5 bits 10110
    DI = 12'hC00;
    xfer(16'h0016, 5, 12'h016, 0, 0, '0, sw);
    check("miso_short", 32'(sw), 32'h18);

    // Long frame: 14 ones; last two MISO bits zero
    DI = 12'h5A5;
    xfer(16'h3FFF, 14, 12'hFFF, 0, 0, '0, sw);
    check("miso_long", 32'(sw), 32'h1694);

    // clr after bit 6; remainder ignored, then a clean frame
    DI = 12'h333;
    xfer(16'h0ABC, 12, 12'h000, 6, 0, '0, sw);
    check("busy_after_abort", 32'(busy), 32'h0);
    DI = 12'h456;
    xfer(16'h05A5, 12, 12'h5A5, 0, 0, '0, sw);
    check("miso_after_clr", 32'(sw), 32'h456);

    // Empty frame
    xfer(16'h0000, 0, 12'h000, 0, 0, '0, sw);

    // SCLK toggling while LOAD high: nothing changes
    MOSI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SCLK = 1'b1; clks(HALF);
      SCLK = 1'b0; clks(HALF);
    end
    check("idle_sclk_busy", 32'(busy), 32'h0);
    check("idle_sclk_cnt", 32'(bit_cnt), 32'h0);
    check("idle_sclk_do", 32'(DO), 32'h0);

    // DI change mid-frame has no effect
    DI = 12'h0F0;
    xfer(16'h0C3C, 12, 12'hC3C, 0, 5, 12'hFFF, sw);
    check("miso_di_stable", 32'(sw), 32'h0F0);

    clks(20);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
